// File: rtl/capture_readback.sv
// Capture buffer: records a programmed number of samples on arm, then streams them out one word per rd_en.
// Optional CAPTURE_DECIMATE_EN adds a decim port that keeps every (decim+1)-th valid sample.
module capture_readback #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [15:0]           length,
`ifdef CAPTURE_DECIMATE_EN
  input  logic [7:0]            decim,
`endif
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   words_left
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, CAPTURE, PREFETCH, READOUT} state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2:0]   eff_len, arm_len, wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_addr;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  keep, mem_we, rd_load, rd_take, done_set;

`ifdef CAPTURE_DECIMATE_EN
  logic [7:0] decim_q, decim_cnt;
  assign keep = (decim_cnt == 8'd0);
`else
  assign keep = 1'b1;
`endif

  // Requests beyond the buffer depth are clamped to a full buffer.
  always_comb begin
    if ({16'd0, length} >= 32'(DEPTH)) arm_len = (DEPTH_LOG2+1)'(DEPTH);
    else                               arm_len = (DEPTH_LOG2+1)'(length);
  end

  assign busy     = (state != IDLE);
  assign rd_ready = (state == READOUT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    mem_we     = 1'b0;
    rd_load    = 1'b0;
    rd_take    = 1'b0;
    done_set   = 1'b0;
    rd_addr    = rd_ptr;
    case (state)
      CAPTURE: begin
        if (sample_valid && keep) begin
          mem_we = 1'b1;
          if (wr_ptr == eff_len - 1'b1) state_next = PREFETCH;
        end
      end
      PREFETCH: begin
        rd_load    = 1'b1;
        rd_addr    = '0;
        state_next = READOUT;
      end
      READOUT: begin
        if (rd_en) begin
          rd_take = 1'b1;
          if (words_left == (DEPTH_LOG2+1)'(1)) begin
            state_next = IDLE;
            done_set   = 1'b1;
          end else begin
            rd_load = 1'b1;
            rd_addr = rd_ptr + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // arm overrides everything, including a coincident read
    if (arm) begin
      state_next = (arm_len == '0) ? IDLE : CAPTURE;
      mem_we     = 1'b0;
      rd_load    = 1'b0;
      rd_take    = 1'b0;
      done_set   = 1'b0;
    end
  end

  // NOTE: the RAM array has no reset; contents are only meaningful below wr_ptr.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[DEPTH_LOG2-1:0]] <= sample_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      eff_len    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      words_left <= '0;
      dout       <= '0;
      done       <= 1'b0;
      underflow  <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
      decim_q    <= '0;
      decim_cnt  <= '0;
`endif
    end else begin
      state <= state_next;
      done  <= done_set;
      if (rd_load) dout <= mem[rd_addr];
      if (arm) begin
        eff_len    <= arm_len;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        words_left <= '0;
        underflow  <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
        decim_q    <= decim;
        decim_cnt  <= '0;
`endif
      end else begin
        if (rd_en && !rd_ready) underflow <= 1'b1;
        if (mem_we) wr_ptr <= wr_ptr + 1'b1;
`ifdef CAPTURE_DECIMATE_EN
        if (state == CAPTURE && sample_valid)
          decim_cnt <= (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
`endif
        if (state == PREFETCH) begin
          words_left <= eff_len;
        end else if (rd_take) begin
          words_left <= words_left - 1'b1;
          rd_ptr     <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_readback.sv
// Directed bench for capture_readback: capture/readout sequences, clamping, underflow, re-arm, async reset.
module tb_capture_readback;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [15:0] length;
  logic [7:0]  decim;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        rd_en;
  logic [15:0] dout;
  logic        rd_ready, busy, done, underflow;
  logic [10:0] words_left;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  capture_readback #(.DEPTH_LOG2(10), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .arm(arm), .length(length),
`ifdef CAPTURE_DECIMATE_EN
    .decim(decim),
`endif
    .sample_in(sample_in), .sample_valid(sample_valid), .rd_en(rd_en),
    .dout(dout), .rd_ready(rd_ready), .busy(busy), .done(done),
    .underflow(underflow), .words_left(words_left)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] len);
    arm = 1'b1;
    length = len;
    tick();
    arm = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rd_ready && n < 20) begin
      tick();
      n++;
    end
    check(tag, rd_ready, 1);
  endtask

  // Reads every word in exp_q with 'gap' idle cycles between strobes, then checks the end-of-readout state.
  task automatic read_words(input string tag, input int gap);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_dout"}, dout, exp_q[i]);
      check({tag, "_left"}, words_left, n - i);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      if (i == n - 1) begin
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, rd_ready, 0);
        check({tag, "_left0"}, words_left, 0);
        check({tag, "_hold"}, dout, exp_q[i]);
      end
      repeat (gap) tick();
    end
    if (gap == 0) tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; length = '0; decim = '0;
    sample_in = '0; sample_valid = 1'b0; rd_en = 1'b0;
    tick(); tick();
    check("rst_dout", dout, 0);
    check("rst_rdy", rd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_uf", underflow, 0);
    check("rst_left", words_left, 0);
    reset = 1'b0;
    tick();

    // Four signed extremes, back-to-back readout
    do_arm(16'd4);
    check("t1_busy", busy, 1);
    feed(16'h0001); feed(16'hFFFF); feed(16'h7FFF); feed(16'h8000);
    check("t1_pref_rdy", rd_ready, 0);
    tick();
    check("t1_rdy", rd_ready, 1);
    exp_q = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    read_words("t1", 0);

    // Length clamped to the 1024-word buffer
    do_arm(16'd2000);
    for (int i = 0; i < 1030; i++) feed(16'(i * 3 + 16'h100));
    wait_ready("t2_rdy");
    check("t2_left", words_left, 1024);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(16'(i * 3 + 16'h100));
    read_words("t2", 0);

    // Zero length never starts
    do_arm(16'd0);
    check("t3_busy0", busy, 0);
    feed(16'h1234);
    tick();
    check("t3_busy1", busy, 0);
    check("t3_left", words_left, 0);

    // Gapped valid samples and gapped reads
    do_arm(16'd3);
    feed(16'hAAAA); tick(); feed(16'h5555); tick(); feed(16'h0F0F);
    wait_ready("t4_rdy");
    exp_q = '{16'hAAAA, 16'h5555, 16'h0F0F};
    read_words("t4", 2);

    // Read strobe during capture raises underflow without touching dout
    do_arm(16'd2);
    feed(16'h1111);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t5_uf", underflow, 1);
    check("t5_dout", dout, 16'h0F0F);
    feed(16'h2222);
    check("t5_uf_sticky", underflow, 1);
    // arm together with rd_en: arm wins and underflow clears
    arm = 1'b1; length = 16'd1; rd_en = 1'b1;
    tick();
    arm = 1'b0; rd_en = 1'b0;
    check("t5_uf_clr", underflow, 0);
    feed(16'h0BAD);
    wait_ready("t5_rdy");
    exp_q = '{16'h0BAD};
    read_words("t5", 0);

    // Re-arm after two of eight words
    do_arm(16'd8);
    for (int i = 0; i < 8; i++) feed(16'h0010 + 16'(i));
    wait_ready("t6_rdy");
    for (int i = 0; i < 2; i++) begin
      check("t6_dout", dout, 16'h0010 + 16'(i));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    do_arm(16'd2);
    check("t6_nodone", done, 0);
    check("t6_busy", busy, 1);
    check("t6_rdy", rd_ready, 0);
    check("t6_left", words_left, 0);
    feed(16'h00A0); feed(16'h00A1);
    wait_ready("t6_rdy2");
    exp_q = '{16'h00A0, 16'h00A1};
    read_words("t6", 0);

    // Asynchronous reset mid-capture
    do_arm(16'd4);
    feed(16'h3333);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t7_pre_uf", underflow, 1);
    #2 reset = 1'b1;
    #1;
    check("t7_busy", busy, 0);
    check("t7_uf", underflow, 0);
    check("t7_dout", dout, 0);
    check("t7_rdy", rd_ready, 0);
    check("t7_left", words_left, 0);
    check("t7_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t7_idle", busy, 0);

`ifdef CAPTURE_DECIMATE_EN
    // Keep every third valid sample
    decim = 8'd2;
    do_arm(16'd3);
    for (int i = 0; i < 9; i++) feed(16'(i));
    wait_ready("t8_rdy");
    exp_q = '{16'd0, 16'd3, 16'd6};
    read_words("t8", 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
